// File: rtl/cmac_tx_pkg.sv
// cmac_tx_pkg: shared widths, beat limit, arbiter state encoding and one-hot grant codes
package cmac_tx_pkg;
  localparam int DEF_DATA_W = 512;
  localparam int DEF_KEEP_W = 64;
  localparam int DEF_MAX_BEATS = 250;
  localparam int DEF_CNT_W = 32;
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_S0 = 2'b01;
  localparam logic [1:0] G_S1 = 2'b10;
endpackage

// File: rtl/cmac_tx_rr_pick.sv
// cmac_tx_rr_pick: 2-way round-robin pick (v0/v1 valids, last_grant 0=s0 1=s1 -> one-hot pick, 00 = none)
module cmac_tx_rr_pick
  import cmac_tx_pkg::*;
(
  input  logic       v0,
  input  logic       v1,
  input  logic       last_grant,
  output logic [1:0] pick
);
  always_comb pick = (v0 && v1) ? (last_grant ? G_S0 : G_S1) : v0 ? G_S0 : v1 ? G_S1 : G_NONE;
endmodule

// File: rtl/cmac_tx_axis_arb.sv
// cmac_tx_axis_arb: packet round-robin arbiter of s0 (ERNIC) / s1 (pkt gen) AXIS onto CMAC m_*, with link gating, truncation to MAX_BEATS, grant/busy and pkt/trunc counters
module cmac_tx_axis_arb
  import cmac_tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int KEEP_W = DEF_KEEP_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              link_up,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic [KEEP_W-1:0] s0_tkeep,
  input  logic              s0_tvalid,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic [KEEP_W-1:0] s1_tkeep,
  input  logic              s1_tvalid,
  input  logic              s1_tlast,
  output logic              s1_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tvalid,
  output logic              m_tlast,
  output logic              m_tuser,
  input  logic              m_tready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic [CNT_W-1:0]  trunc_cnt
);
  localparam int BW = $clog2(MAX_BEATS);
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d, pick;
  logic last_q, last_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d, pkt_cnt1_q, pkt_cnt1_d, trunc_cnt_q, trunc_cnt_d;
  logic sel, src_valid, src_last, take, acc, done, trunc;
  cmac_tx_rr_pick u_pick (
    .v0        (s0_tvalid),
    .v1        (s1_tvalid),
    .last_grant(last_q),
    .pick      (pick)
  );
  always_comb begin
    sel = grant_q[1];
    src_valid = sel ? s1_tvalid : s0_tvalid;
    src_last = sel ? s1_tlast : s0_tlast;
    take = state_q == DROP || (state_q == PASS && m_tready);
    acc = src_valid && take;
    done = acc && src_last;
    trunc = state_q == PASS && src_valid && !src_last && beat_q == BW'(MAX_BEATS - 1);
    m_tdata = sel ? s1_tdata : s0_tdata;
    m_tkeep = sel ? s1_tkeep : s0_tkeep;
    m_tvalid = state_q == PASS && src_valid;
    m_tlast = state_q == PASS && (src_last || trunc);
    m_tuser = trunc;
    s0_tready = !sel && take;
    s1_tready = sel && take;
    state_d = state_q == IDLE ? ((link_up && pick != G_NONE) ? PASS : IDLE) :
              done ? IDLE : (trunc && m_tready) ? DROP : state_q;
    grant_d = state_q == IDLE ? (link_up ? pick : G_NONE) : done ? G_NONE : grant_q;
    beat_d = (state_q == PASS && acc) ? ((src_last || trunc) ? '0 : beat_q + BW'(1)) : beat_q;
    last_d = (state_q == PASS && acc && (src_last || trunc)) ? sel : last_q;
    pkt_cnt0_d = pkt_cnt0_q + CNT_W'(state_q == PASS && done && !sel);
    pkt_cnt1_d = pkt_cnt1_q + CNT_W'(state_q == PASS && done && sel);
    trunc_cnt_d = trunc_cnt_q + CNT_W'(trunc && m_tready);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= G_NONE;
      last_q <= 1'b1;
      beat_q <= '0;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
      trunc_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      beat_q <= beat_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end
  assign grant = grant_q;
  assign busy = state_q != IDLE;
  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
  assign trunc_cnt = trunc_cnt_q;
endmodule

// File: tb/tb_cmac_tx_axis_arb.sv
// tb_cmac_tx_axis_arb: randomized directed bench checking the arbiter against a packet-level round-robin model
module tb_cmac_tx_axis_arb;
  localparam int MAX_BEATS = 250;
  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         user;
  } beat_t;
  logic clk = 0, reset = 1, link_up = 1, m_tready = 1;
  logic [511:0] s0_tdata, s1_tdata, m_tdata;
  logic [63:0] s0_tkeep, s1_tkeep, m_tkeep;
  logic s0_tvalid, s0_tlast, s0_tready, s1_tvalid, s1_tlast, s1_tready;
  logic m_tvalid, m_tlast, m_tuser, busy;
  logic [1:0] grant;
  logic [31:0] pkt_cnt0, pkt_cnt1, trunc_cnt;
  beat_t q0[$], q1[$], p0[$], p1[$], exp_q[$], obs[$];
  int obs_cyc[$];
  int checks = 0, failures = 0, cyc = 0;
  bit m_last = 1, tog = 0, rnd = 0, mir = 0, gap0 = 0;

  cmac_tx_axis_arb dut (
    .clk(clk), .reset(reset), .link_up(link_up),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tready(m_tready), .grant(grant), .busy(busy),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .trunc_cnt(trunc_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    bit hs;
    s0_tvalid = 0; s0_tdata = '0; s0_tkeep = '0; s0_tlast = 0;
    forever begin
      @(negedge clk);
      hs = s0_tvalid && s0_tready;
      @(posedge clk);
      #1;
      if (hs && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() == 0) s0_tvalid = 0;
      else if (hs || !s0_tvalid) s0_tvalid = !gap0 || $urandom_range(0, 2) != 0;
      if (q0.size() > 0) {s0_tdata, s0_tkeep, s0_tlast} = {q0[0].data, q0[0].keep, q0[0].last};
    end
  end

  initial begin
    bit hs;
    s1_tvalid = 0; s1_tdata = '0; s1_tkeep = '0; s1_tlast = 0;
    forever begin
      @(negedge clk);
      hs = s1_tvalid && s1_tready;
      @(posedge clk);
      #1;
      if (hs && q1.size() > 0) void'(q1.pop_front());
      s1_tvalid = q1.size() > 0;
      if (q1.size() > 0) {s1_tdata, s1_tkeep, s1_tlast} = {q1[0].data, q1[0].keep, q1[0].last};
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset && m_tvalid && m_tready) begin
        obs.push_back(beat_t'{m_tdata, m_tkeep, m_tlast, m_tuser});
        obs_cyc.push_back(cyc);
      end
      if (mir && grant === 2'b10) begin
        checks += 2;
        assert (s1_tready === m_tready) else begin failures++; $error("FAIL s1_tready_mirror: got %b expected %b", s1_tready, m_tready); end
        assert (s0_tready === 1'b0) else begin failures++; $error("FAIL s0_tready_idle: got %b expected 0", s0_tready); end
      end
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    checks++;
    assert (got === want) else begin failures++; $error("FAIL %s: got %0h expected %0h", tag, got, want); end
  endtask

  function automatic beat_t rand_beat(bit last);
    beat_t b;
    for (int i = 0; i < 16; i++) b.data[i*32 +: 32] = $urandom;
    b.keep = {$urandom, $urandom};
    b.last = last;
    b.user = 0;
    return b;
  endfunction

  task automatic add_pkt(int src, int n, bit term);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = rand_beat(term && i == n - 1);
      if (src == 1) begin q1.push_back(b); p1.push_back(b); end
      else begin q0.push_back(b); p0.push_back(b); end
    end
  endtask

  // Packet-level reference: whole packets, round-robin when both sides pending, cut at MAX_BEATS
  task automatic model_rr();
    beat_t a[$], b[$], x;
    bit src, done;
    int n;
    a = p0; b = p1; p0.delete(); p1.delete();
    while (a.size() > 0 || b.size() > 0) begin
      src = (a.size() > 0 && b.size() > 0) ? !m_last : (b.size() > 0);
      n = 0; done = 0;
      while (!done) begin
        x = src ? b.pop_front() : a.pop_front();
        n++;
        done = x.last;
        if (n < MAX_BEATS) exp_q.push_back(x);
        else if (n == MAX_BEATS) begin x.user = !x.last; x.last = 1; exp_q.push_back(x); end
      end
      m_last = src;
    end
  endtask

  task automatic check_stream(string tag);
    checks++;
    assert (obs.size() == exp_q.size()) else begin failures++; $error("FAIL %s_len: got %0d beats expected %0d", tag, obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      assert (obs[i] === exp_q[i]) else begin
        failures++;
        $error("FAIL %s beat %0d: got last=%b user=%b keep=%h data=%h expected last=%b user=%b keep=%h data=%h",
               tag, i, obs[i].last, obs[i].user, obs[i].keep, obs[i].data[63:0],
               exp_q[i].last, exp_q[i].user, exp_q[i].keep, exp_q[i].data[63:0]);
      end
    end
  endtask

  task automatic wait_done(string tag, int maxc);
    int c = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && busy === 1'b0 && obs.size() >= exp_q.size()) && c < maxc) begin
      @(posedge clk);
      #1;
      if (tog) m_tready = ~m_tready;
      else if (rnd) m_tready = 1'($urandom_range(0, 1));
      c++;
    end
    checks++;
    assert (c < maxc) else begin failures++; $error("FAIL %s_timeout: got %0d cycles expected fewer than %0d", tag, c, maxc); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_obs(string tag, int n, int maxc);
    int c = 0;
    while (obs.size() < n && c < maxc) begin
      @(posedge clk);
      #1;
      c++;
    end
    checks++;
    assert (obs.size() >= n) else begin failures++; $error("FAIL %s_wait: got %0d beats expected %0d", tag, obs.size(), n); end
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); p0.delete(); p1.delete();
    obs.delete(); obs_cyc.delete(); exp_q.delete();
    m_last = 1;
  endtask

  task automatic do_reset();
    reset = 1; m_tready = 1; link_up = 1; tog = 0; rnd = 0; mir = 0; gap0 = 0;
    @(negedge clk);
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_m_tvalid"}, 64'(m_tvalid), 0);
    chk({tag, "_s0_tready"}, 64'(s0_tready), 0);
    chk({tag, "_s1_tready"}, 64'(s1_tready), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_grant"}, 64'(grant), 0);
    chk({tag, "_m_tuser"}, 64'(m_tuser), 0);
    chk({tag, "_pkt_cnt0"}, 64'(pkt_cnt0), 0);
    chk({tag, "_pkt_cnt1"}, 64'(pkt_cnt1), 0);
    chk({tag, "_trunc_cnt"}, 64'(trunc_cnt), 0);
  endtask

  initial begin
    // reset values, then s0-only: three 9-beat packets with one bubble each
    do_reset();
    @(negedge clk);
    check_reset_state("rst");
    for (int i = 0; i < 3; i++) add_pkt(0, 9, 1);
    model_rr();
    wait_done("s0only", 200);
    check_stream("s0only");
    chk("s0only_pkt_cnt0", 64'(pkt_cnt0), 3);
    chk("s0only_pkt_cnt1", 64'(pkt_cnt1), 0);
    if (obs_cyc.size() == 27) chk("s0only_span", 64'(obs_cyc[26] - obs_cyc[0]), 28);

    // both sources continuously valid: strict alternation starting with s0
    do_reset();
    rnd = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin add_pkt(0, 4, 1); add_pkt(1, 4, 1); end
    model_rr();
    wait_done("alt", 500);
    check_stream("alt");
    chk("alt_pkt_cnt0", 64'(pkt_cnt0), 4);
    chk("alt_pkt_cnt1", 64'(pkt_cnt1), 4);

    // m_tready toggling during an s1 packet
    do_reset();
    tog = 1; mir = 1;
    @(negedge clk);
    add_pkt(1, 8, 1);
    model_rr();
    wait_done("toggle", 200);
    check_stream("toggle");
    chk("toggle_pkt_cnt1", 64'(pkt_cnt1), 1);
    mir = 0;

    // link down blocks grants; dropping it mid-packet lets the packet finish
    do_reset();
    link_up = 0;
    @(negedge clk);
    add_pkt(0, 6, 1);
    add_pkt(1, 6, 1);
    model_rr();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("linkdown_beats", 64'(obs.size()), 0);
    chk("linkdown_grant", 64'(grant), 0);
    chk("linkdown_m_tvalid", 64'(m_tvalid), 0);
    chk("linkdown_s0_tready", 64'(s0_tready), 0);
    chk("linkdown_s1_tready", 64'(s1_tready), 0);
    link_up = 1;
    wait_obs("linkmid", 2, 50);
    link_up = 0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("linkmid_beats", 64'(obs.size()), 6);
    chk("linkmid_grant", 64'(grant), 0);
    chk("linkmid_pkt_cnt0", 64'(pkt_cnt0), 1);
    link_up = 1;
    wait_done("link", 200);
    check_stream("link");
    chk("link_pkt_cnt1", 64'(pkt_cnt1), 1);

    // exact MAX_BEATS packet on s0, runaway 260-beat packet on s1, then a normal s1 packet
    do_reset();
    @(negedge clk);
    add_pkt(0, MAX_BEATS, 1);
    add_pkt(1, 260, 1);
    add_pkt(1, 5, 1);
    model_rr();
    wait_done("trunc", 2000);
    check_stream("trunc");
    chk("trunc_cnt", 64'(trunc_cnt), 1);
    chk("trunc_pkt_cnt0", 64'(pkt_cnt0), 1);
    chk("trunc_pkt_cnt1", 64'(pkt_cnt1), 1);
    chk("trunc_busy", 64'(busy), 0);

    // s0 with random valid gaps and random back-pressure
    do_reset();
    gap0 = 1; rnd = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) add_pkt(0, $urandom_range(1, 12), 1);
    model_rr();
    wait_done("gaps", 1000);
    check_stream("gaps");
    chk("gaps_pkt_cnt0", 64'(pkt_cnt0), 5);

    // reset in the middle of a packet
    do_reset();
    @(negedge clk);
    add_pkt(0, 3, 1);
    add_pkt(0, 10, 1);
    wait_obs("midrst", 8, 100);
    chk("midrst_pre_pkt_cnt0", 64'(pkt_cnt0), 1);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midrst");
    clear_all();
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    add_pkt(1, 4, 1);
    add_pkt(0, 5, 1);
    model_rr();
    wait_done("postrst", 200);
    check_stream("postrst");
    chk("postrst_pkt_cnt0", 64'(pkt_cnt0), 1);
    chk("postrst_pkt_cnt1", 64'(pkt_cnt1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmac_tx_axis_arb.md
Name: cmac_tx_axis_arb

Overview:
Packet-boundary round-robin arbiter that shares the single CMAC TX AXI4-Stream port (512-bit, tx_axis_*) between two requesters: port 0 is the ERNIC TX stream and port 1 is the test packet generator stream.
It sits between exdes_top / cmac_usplus_0_axis_pkt_gen and the CMAC IP, in the txusrclk2 domain.
It never interleaves packets, gates new grants on link readiness, and truncates runaway packets.
It also keeps per-source packet and error counters for ILA and debug.

Parameters:
DATA_W, 512, stream data width
KEEP_W, 64, tkeep width (DATA_W/8)
MAX_BEATS, 250, max beats per packet (16000 B / 64 B); beat MAX_BEATS without tlast triggers truncation
CNT_W, 32, statistics counter width

Ports:
clk  in  1  txusrclk2
reset  in  1  synchronous active-high (usr_tx_reset)
link_up  in  1  ctl_tx_enable AND tx_gt_locked; new grants only when 1
s0_tdata  in  DATA_W  ERNIC data
s0_tkeep  in  KEEP_W  ERNIC keep
s0_tvalid  in  1  ERNIC valid
s0_tlast  in  1  ERNIC last
s0_tready  out  1  ERNIC ready
s1_tdata, s1_tkeep, s1_tvalid, s1_tlast, s1_tready  same widths and directions as s0_*  test-generator stream
m_tdata  out  DATA_W  to CMAC tx_axis_tdata
m_tkeep  out  KEEP_W  to CMAC tx_axis_tkeep
m_tvalid  out  1  to CMAC tx_axis_tvalid
m_tlast  out  1  to CMAC tx_axis_tlast
m_tuser  out  1  to CMAC tx_axis_tuser; 1 = errored packet
m_tready  in  1  from CMAC tx_axis_tready
grant  out  2  one-hot registered grant; 00 = none
busy  out  1  state != IDLE
pkt_cnt0  out  CNT_W  packets completed from s0
pkt_cnt1  out  CNT_W  packets completed from s1
trunc_cnt  out  CNT_W  packets truncated, both sources

Behaviour:
- Reset: state=IDLE, grant=00, last_grant=1 (so s0 wins first), beat_cnt=0, all counters=0. m_tvalid=0, s0_tready=0, s1_tready=0, busy=0, m_tuser=0.
- States: IDLE, PASS, DROP.
- IDLE:
  - If link_up=1 and any sX_tvalid=1, register grant.
  - Only one valid: grant it. Both valid: grant the source != last_grant.
  - Go to PASS next cycle. Exactly one bubble cycle per packet.
  - link_up=0: stay in IDLE; both treadys stay 0.
- PASS, combinational pass-through (zero latency):
  - m_* = granted s_*; granted s_tready = m_tready; other s_tready = 0; m_tuser=0.
  - Beat accepted when m_tvalid & m_tready; beat_cnt increments on each accepted beat.
  - Accepted beat with tlast=1: increment pkt_cntX, set last_grant=X, clear beat_cnt, go to IDLE, grant=00.
  - Accepted beat with beat_cnt==MAX_BEATS-1 and tlast=0: force m_tlast=1 and m_tuser=1 on that beat, increment trunc_cnt (not pkt_cnt), set last_grant=X, go to DROP.
- DROP:
  - m_tvalid=0; granted s_tready=1; source beats are discarded.
  - Granted source's tlast beat accepted: go to IDLE, grant=00.
- link_up falling mid-packet: the current packet completes normally; the arbiter never cuts a packet. Only the next grant is blocked.
- Source deasserts tvalid mid-packet: m_tvalid follows it (underflow is the source's fault); grant is held.
- Counters wrap modulo 2^CNT_W with no saturation.
- Reset asserted mid-packet: immediate return to reset values on the next edge; the partial packet is abandoned.
- tdata and tkeep are passed unmodified; tkeep is not checked.

Decomposition:
- Shared package cmac_tx_pkg: DATA_W/KEEP_W defaults, MAX_BEATS, state enum {IDLE, PASS, DROP}, grant encoding constants.
- One sub-module is natural: cmac_tx_rr_pick, a 2-way round-robin pick from valids and last_grant (combinational).
- FSM, beat counter and statistics live in the top module.

Test Plan:
- s0 only, 3 packets of 9 beats, m_tready=1 -> 27 beats out in order, 1 idle cycle between packets, pkt_cnt0=3, pkt_cnt1=0, m_tuser=0 throughout.
- s0 and s1 both continuously valid, 4-beat packets -> output alternates s0,s1,s0,s1 starting with s0; no interleaving inside a packet; after 8 packets pkt_cnt0=4, pkt_cnt1=4.
- m_tready toggling 1010… during an s1 packet -> every beat appears exactly once; s1_tready mirrors m_tready; s0_tready stays 0.
- link_up=0 with both sources valid -> m_tvalid=0 and grant=00 indefinitely. link_up dropped mid-packet -> that packet finishes, then no new grant.
- s1 sends 260 beats without tlast -> beat 250 is output with m_tlast=1, m_tuser=1; beats 251–260 are consumed with m_tvalid=0; trunc_cnt=1, pkt_cnt1 unchanged.
- reset pulsed at beat 5 of a packet -> next cycle all outputs are at reset values; the following s0 packet is granted first.
